aes_stream_packer: RTL and testbench
====================================

# aes_stream_packer

Width adapter between the plaintext source streamer and the AES engine in the AES HWPE datapath. Gathers 32-bit stream words into 128-bit AES state blocks, hands each block to the engine over a valid/ready handshake, and counts blocks against a programmed job length. Signals job completion to the controlling FSM.

## Interface
- WORD_W, 32, stream word width.
- BLK_W, 128, AES block width. BLK_W/WORD_W (NW, 4 by default) must be an integer ≥ 2.
- CNT_W, 16, width of the block counter and of the job length.

- clk  in  1  clock; all logic rises on posedge.
- reset_n  in  1  synchronous, active-low reset. There is one clock, and reset is synchronous and active-low.
- clear_i  in  1  synchronous soft clear; same effect as reset.
- start_i  in  1  job start; sampled only in IDLE.
- n_blocks_i  in  CNT_W  number of blocks in the job; sampled with start_i.
- in_data_i  in  WORD_W  plaintext word from the source streamer.
- in_valid_i  in  1  word valid.
- in_ready_o  out  1  word accepted when in_valid_i and in_ready_o are both high.
- blk_data_o  out  BLK_W  packed AES block to the engine.
- blk_valid_o  out  1  block valid.
- blk_ready_i  in  1  engine accepts the block.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse at job end.
- blk_cnt_o  out  CNT_W  blocks accepted by the engine in the current job.

## Operation
- States are IDLE, FILL, EMIT and DONE.
- **IDLE**
  - in_ready_o=0 and blk_valid_o=0.
  - On start_i: latch n_blocks_i, clear blk_cnt_o, clear the word index.
  - If n_blocks_i=0, go to DONE; otherwise go to FILL.
- **FILL**
  - in_ready_o=1.
  - Each input handshake stores in_data_i into slot idx. Word 0 goes to blk_data_o[BLK_W-1 -: WORD_W]. Word NW-1 goes to bits [WORD_W-1:0]. This puts AES byte 0 in the MSB.
  - idx increments on each handshake. On the handshake with idx=NW-1, idx wraps to 0 and the state goes to EMIT.
- **EMIT**
  - blk_valid_o=1 and in_ready_o=0.
  - blk_data_o holds stable until the engine handshake.
  - blk_valid_o never depends combinationally on blk_ready_i.
  - On handshake, blk_cnt_o increments. If the new count equals the latched n_blocks, go to DONE; otherwise go to FILL.
- **DONE**
  - done_o=1 for exactly one cycle, then go to IDLE.
  - blk_cnt_o holds its final value until the next start.
- Words offered while in_ready_o=0 are not consumed. The streamer keeps them pending.
- start_i outside IDLE is ignored. n_blocks_i changes outside IDLE have no effect.
- Counter arithmetic is CNT_W-bit unsigned. The maximum job is 2^CNT_W−1 blocks, and the counter never wraps within a job.
- Reset or clear_i in any state:
  - Return to IDLE and discard any partial block.
  - Drive all outputs to their reset values on the next cycle.
  - reset_n has priority over clear_i.

## Timing
- Reset values: in_ready_o=0, blk_valid_o=0, blk_data_o=0, busy_o=0, done_o=0, blk_cnt_o=0, idx=0.
- in_ready_o rises the cycle after start_i is sampled.
- blk_valid_o rises the cycle after the NWth input handshake. Minimum latency from the last word to block valid is 1 cycle.
- Minimum block period is NW+1 cycles (4 FILL plus 1 EMIT at default parameters) when in_valid_i and blk_ready_i are held high.
- done_o asserts the cycle after the final engine handshake. busy_o drops the cycle after done_o.
- With n_blocks_i=0, done_o asserts the cycle after start_i. No input handshake occurs.
- All outputs are registered or decoded from state and registers only. There is no combinational in→out path.

## Test plan
- **Single block.** Reset, then start_i with n_blocks_i=1. Feed 0x00112233, 0x44556677, 0x8899AABB and 0xCCDDEEFF back to back with blk_ready_i=1.
  - blk_valid_o is high for 1 cycle with blk_data_o=0x00112233_44556677_8899AABB_CCDDEEFF.
  - done_o pulses the next cycle. blk_cnt_o=1.
- **Backpressure.** n_blocks_i=2, blk_ready_i=0 for 5 cycles after the first block.
  - blk_data_o stays stable and in_ready_o=0 throughout the stall.
  - After release, the second block packs correctly and blk_cnt_o reaches 2 before done_o.
- **Gapped input.** in_valid_i toggles 1,0,1,0,… across 8 words with n_blocks_i=2.
  - Word order is preserved in both blocks.
  - idx wraps correctly and no word is lost or duplicated.
- **Zero-length job.** start_i with n_blocks_i=0.
  - done_o pulses 1 cycle later.
  - in_ready_o and blk_valid_o never assert. blk_cnt_o=0.
- **Mid-job abort.** Feed 2 words, then pulse clear_i (repeat with reset_n=0).
  - The next cycle is IDLE with all outputs at their reset values.
  - A fresh 1-block job afterwards produces only the new words.
- **Ignored start.** Assert start_i with n_blocks_i=5 during FILL of a 1-block job.
  - The job ends after 1 block. The latched length is unchanged.

Source files
------------

// File: rtl/aes_stream_packer_if.sv
// Word-in / block-out handshake bundle between the source streamer, the packer and the AES engine.
// The master modport is the packer; the slave modport is the streamer/engine side.
interface aes_stream_packer_if #(
  parameter int WORD_W = 32,
  parameter int BLK_W  = 128
);
  logic [WORD_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [BLK_W-1:0]  blk_data;
  logic              blk_valid;
  logic              blk_ready;

  modport master (
    input  in_data, in_valid, blk_ready,
    output in_ready, blk_data, blk_valid
  );

  modport slave (
    output in_data, in_valid, blk_ready,
    input  in_ready, blk_data, blk_valid
  );
endinterface

// File: rtl/aes_stream_packer.sv
// Packs WORD_W stream words into BLK_W AES blocks (first word in the MSBs).
// Counts the blocks the engine accepts against a latched job length.
//
// state | meaning
// IDLE  | waiting for start_i, no handshakes offered
// FILL  | accepting words into the block buffer
// EMIT  | full block offered to the engine, input stalled
// DONE  | one-cycle job-complete pulse
module aes_stream_packer #(
  parameter int WORD_W = 32,
  parameter int BLK_W  = 128,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] n_blocks_i,
  aes_stream_packer_if.master s_if,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] blk_cnt_o
);

  localparam int NW    = BLK_W / WORD_W;
  localparam int IDX_W = $clog2(NW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [BLK_W-1:0]   blk_q, blk_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   nblk_q, nblk_d;
  logic [CNT_W-1:0]   cnt_inc;

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!reset_n || clear_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      blk_q   <= '0;
      cnt_q   <= '0;
      nblk_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      blk_q   <= blk_d;
      cnt_q   <= cnt_d;
      nblk_q  <= nblk_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    blk_d   = blk_q;
    cnt_d   = cnt_q;
    nblk_d  = nblk_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          nblk_d  = n_blocks_i;
          cnt_d   = '0;
          idx_d   = '0;
          state_d = (n_blocks_i == '0) ? DONE : FILL;
        end
      end
      FILL: begin
        if (s_if.in_valid) begin
          // Slot 0 lands in the MSBs so AES byte 0 is the top byte of the block.
          for (int s = 0; s < NW; s++) begin
            if (idx_q == IDX_W'(s)) begin
              blk_d[BLK_W-1-s*WORD_W -: WORD_W] = s_if.in_data;
            end
          end
          if (idx_q == IDX_W'(NW-1)) begin
            idx_d   = '0;
            state_d = EMIT;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      EMIT: begin
        if (s_if.blk_ready) begin
          cnt_d   = cnt_inc;
          state_d = (cnt_inc == nblk_q) ? DONE : FILL;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign s_if.in_ready  = (state_q == FILL);
  assign s_if.blk_valid = (state_q == EMIT);
  assign s_if.blk_data  = blk_q;
  assign busy_o         = (state_q != IDLE);
  assign done_o         = (state_q == DONE);
  assign blk_cnt_o      = cnt_q;

endmodule

// File: tb/tb_aes_stream_packer.sv
// Scoreboard bench for aes_stream_packer: the driver pushes expected blocks and job counts,
// an independent monitor pops and compares whenever the DUT hands out a block or a done pulse.
module tb_aes_stream_packer;
  localparam int WORD_W = 32;
  localparam int BLK_W  = 128;
  localparam int CNT_W  = 16;
  localparam int NW     = 4;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             clear_i = 1'b0;
  logic             start_i = 1'b0;
  logic [CNT_W-1:0] n_blocks_i = '0;
  logic             busy_o;
  logic             done_o;
  logic [CNT_W-1:0] blk_cnt_o;

  aes_stream_packer_if #(.WORD_W(WORD_W), .BLK_W(BLK_W)) bus ();

  aes_stream_packer #(.WORD_W(WORD_W), .BLK_W(BLK_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear_i    (clear_i),
    .start_i    (start_i),
    .n_blocks_i (n_blocks_i),
    .s_if       (bus.master),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .blk_cnt_o  (blk_cnt_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [BLK_W-1:0] exp_blk_q[$];
  int               exp_done_q[$];
  int               done_seen = 0;
  int               last_word_cyc = -10;
  int               last_blk_cyc = -10;
  int               rdy_mode = 0;

  task automatic chk(input string name, input logic [BLK_W-1:0] act, input logic [BLK_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: event did not happen within its cycle budget", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Engine back-pressure: 0 always ready, 1 random, 2 stalled.
  always begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0: bus.blk_ready = 1'b1;
      1: bus.blk_ready = 1'($urandom_range(0, 1));
      default: bus.blk_ready = 1'b0;
    endcase
  end

  // Monitor
  logic             prev_valid = 1'b0;
  logic             prev_done = 1'b0;
  logic             stalled = 1'b0;
  logic [BLK_W-1:0] held = '0;

  always @(negedge clk) begin
    if (bus.blk_valid) begin
      chk("in_ready_low_in_emit", BLK_W'(bus.in_ready), '0);
      if (!prev_valid) chk("valid_latency", BLK_W'(cyc), BLK_W'(last_word_cyc + 1));
      else if (stalled) chk("stall_stable", bus.blk_data, held);
      if (bus.blk_ready) begin
        if (exp_blk_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_block: got %h expected no block", bus.blk_data);
        end else begin
          chk("block_data", bus.blk_data, exp_blk_q.pop_front());
        end
        last_blk_cyc = cyc;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held = bus.blk_data;
      end
    end else begin
      stalled = 1'b0;
    end
    if (done_o) begin
      if (exp_done_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done with count %0d expected none", blk_cnt_o);
      end else begin
        int n;
        n = exp_done_q.pop_front();
        chk("done_count", BLK_W'(blk_cnt_o), BLK_W'(n));
        if (n > 0) chk("done_latency", BLK_W'(cyc), BLK_W'(last_blk_cyc + 1));
      end
      done_seen++;
    end
    if (prev_done) chk("busy_after_done", BLK_W'(busy_o), '0);
    prev_valid = bus.blk_valid;
    prev_done  = done_o;
  end

  task automatic send_word(input logic [WORD_W-1:0] w, input bit last, output bit ok);
    bus.in_data  = w;
    bus.in_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        if (last) last_word_cyc = cyc;
      end
      step();
    end
    bus.in_valid = 1'b0;
    if (!ok) fail_now("word_accept");
  endtask

  task automatic gap(input int gmode);
    int n;
    n = (gmode == 0) ? 0 : (gmode == 1) ? 1 : int'($urandom_range(0, 2));
    bus.in_valid = 1'b0;
    repeat (n) step();
  endtask

  logic [WORD_W-1:0] fixed_w[NW] = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};

  task automatic run_job(input int n, input int gmode, input bit poke, input bit fixed);
    int ds;
    bit ok;
    logic [BLK_W-1:0] blk;
    logic [WORD_W-1:0] w;
    ds = done_seen;
    exp_done_q.push_back(n);
    n_blocks_i = CNT_W'(n);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    n_blocks_i = CNT_W'($urandom);
    @(negedge clk);
    if (n == 0) begin
      chk("zero_done_pulse", BLK_W'(done_o), BLK_W'(1));
      chk("zero_in_ready", BLK_W'(bus.in_ready), '0);
    end else begin
      chk("in_ready_rise", BLK_W'(bus.in_ready), BLK_W'(1));
    end
    step();
    for (int b = 0; b < n; b++) begin
      blk = '0;
      for (int k = 0; k < NW; k++) begin
        w = fixed ? fixed_w[k] : WORD_W'($urandom);
        blk = {blk[BLK_W-WORD_W-1:0], w};
        if (poke && b == 0 && k == 1) begin
          start_i = 1'b1;
          n_blocks_i = CNT_W'(5);
        end
        send_word(w, k == NW-1, ok);
        start_i = 1'b0;
        if (!ok) break;
        if (k == NW-1) exp_blk_q.push_back(blk);
        gap(gmode);
      end
      if (!ok) break;
    end
    for (int t = 0; t < 500 && done_seen == ds; t++) step();
    if (done_seen == ds) begin
      fail_now("job_done");
      exp_done_q.delete();
      exp_blk_q.delete();
    end
  endtask

  task automatic run_abort(input bit use_rst);
    bit ok;
    n_blocks_i = CNT_W'(1);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    send_word(WORD_W'($urandom), 1'b0, ok);
    send_word(WORD_W'($urandom), 1'b0, ok);
    if (use_rst) reset_n = 1'b0;
    else clear_i = 1'b1;
    step();
    reset_n = 1'b1;
    clear_i = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", BLK_W'(bus.in_ready), '0);
    chk("abort_blk_valid", BLK_W'(bus.blk_valid), '0);
    chk("abort_blk_data", bus.blk_data, '0);
    chk("abort_busy", BLK_W'(busy_o), '0);
    chk("abort_done", BLK_W'(done_o), '0);
    chk("abort_blk_cnt", BLK_W'(blk_cnt_o), '0);
    step();
    run_job(1, 0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.blk_ready = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk("reset_in_ready", BLK_W'(bus.in_ready), '0);
    chk("reset_blk_valid", BLK_W'(bus.blk_valid), '0);
    chk("reset_blk_data", bus.blk_data, '0);
    chk("reset_busy", BLK_W'(busy_o), '0);
    chk("reset_blk_cnt", BLK_W'(blk_cnt_o), '0);
    step();
    reset_n = 1'b1;
    step();

    run_job(1, 0, 1'b0, 1'b1);

    rdy_mode = 2;
    fork
      run_job(2, 0, 1'b0, 1'b0);
      begin
        for (int t = 0; t < 200 && !bus.blk_valid; t++) @(negedge clk);
        repeat (5) step();
        rdy_mode = 0;
      end
    join

    run_job(2, 1, 1'b0, 1'b0);
    run_job(0, 0, 1'b0, 1'b0);
    run_abort(1'b0);
    run_abort(1'b1);

    run_job(1, 0, 1'b1, 1'b0);
    repeat (4) step();
    @(negedge clk);
    chk("ignored_start_idle", BLK_W'(busy_o), '0);
    step();

    rdy_mode = 1;
    for (int j = 0; j < 12; j++) begin
      run_job(int'($urandom_range(0, 4)), int'($urandom_range(0, 2)), 1'b0, 1'b0);
      repeat (int'($urandom_range(0, 3))) step();
    end
    rdy_mode = 0;
    repeat (3) step();
    chk("scoreboard_empty", BLK_W'(exp_blk_q.size()), '0);
    chk("done_queue_empty", BLK_W'(exp_done_q.size()), '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
